vedic_add_seq: RTL

VEDIC_ADD_SEQ -- requirements
Module: vedic_add_seq

---
 rtl/vedic_add_seq.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/vedic_add_seq.sv
// Sequential combiner of four 4x4 Vedic partial products into a 16-bit product
// using one time-shared 8-bit adder. Define VEDIC_ADD_SEQ_OVF_EN to add the ovf output.
module vedic_add_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  pp_ll,
  input  logic [7:0]  pp_lh,
  input  logic [7:0]  pp_hl,
  input  logic [7:0]  pp_hh,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
`ifdef VEDIC_ADD_SEQ_OVF_EN
  ,
  output logic        ovf
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LH_LO = 3'd1,
    LH_HI = 3'd2,
    HL_LO = 3'd3,
    HL_HI = 3'd4,
    HH_HI = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic        carry_q, carry_d;
  logic [7:0]  lh_q, lh_d;
  logic [7:0]  hl_q, hl_d;
  logic [7:0]  hh_q, hh_d;
  logic [15:0] product_q, product_d;

  logic [15:0] opnd;
  logic        hi_pass;
  logic [7:0]  add_a, add_b, add_s;
  logic        add_ci, add_co;

`ifdef VEDIC_ADD_SEQ_OVF_EN
  logic ovf_acc_q, ovf_acc_d;
  logic ovf_q, ovf_d;
`endif

  // Operand and pass selection feeding the single shared adder.
  always_comb begin
    opnd = '0;
    unique case (state_q)
      LH_LO, LH_HI: opnd = {4'h0, lh_q, 4'h0};
      HL_LO, HL_HI: opnd = {4'h0, hl_q, 4'h0};
      HH_HI:        opnd = {hh_q, 8'h00};
      default:      opnd = '0;
    endcase
    hi_pass = (state_q == LH_HI) || (state_q == HL_HI) || (state_q == HH_HI);
    add_a   = hi_pass ? acc_q[15:8] : acc_q[7:0];
    add_b   = hi_pass ? opnd[15:8]  : opnd[7:0];
    add_ci  = ((state_q == LH_HI) || (state_q == HL_HI)) ? carry_q : 1'b0;
    {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_ci};
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    lh_d      = lh_q;
    hl_d      = hl_q;
    hh_d      = hh_q;
    product_d = product_q;
`ifdef VEDIC_ADD_SEQ_OVF_EN
    ovf_acc_d = ovf_acc_q;
    ovf_d     = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          lh_d    = pp_lh;
          hl_d    = pp_hl;
          hh_d    = pp_hh;
          acc_d   = {8'h00, pp_ll};
          carry_d = 1'b0;
`ifdef VEDIC_ADD_SEQ_OVF_EN
          ovf_acc_d = 1'b0;
`endif
          state_d = LH_LO;
        end
      end
      LH_LO, HL_LO: begin
        acc_d[7:0] = add_s;
        carry_d    = add_co;
        state_d    = (state_q == LH_LO) ? LH_HI : HL_HI;
      end
      LH_HI, HL_HI: begin
        acc_d[15:8] = add_s;
        carry_d     = 1'b0;
`ifdef VEDIC_ADD_SEQ_OVF_EN
        ovf_acc_d = ovf_acc_q | add_co;
`endif
        state_d     = (state_q == LH_HI) ? HL_LO : HH_HI;
      end
      HH_HI: begin
        // Low byte is final after HL_LO; only the high byte changes here.
        acc_d[15:8] = add_s;
        product_d   = {add_s, acc_q[7:0]};
`ifdef VEDIC_ADD_SEQ_OVF_EN
        ovf_d = ovf_acc_q | add_co;
`endif
        state_d     = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      lh_q      <= '0;
      hl_q      <= '0;
      hh_q      <= '0;
      product_q <= '0;
`ifdef VEDIC_ADD_SEQ_OVF_EN
      ovf_acc_q <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      carry_q   <= carry_d;
      lh_q      <= lh_d;
      hl_q      <= hl_d;
      hh_q      <= hh_d;
      product_q <= product_d;
`ifdef VEDIC_ADD_SEQ_OVF_EN
      ovf_acc_q <= ovf_acc_d;
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign product = product_q;
`ifdef VEDIC_ADD_SEQ_OVF_EN
  assign ovf     = ovf_q;
`endif

endmodule
